// File: rtl/ram_pkg.sv
// Shared constants, command encodings and FSM state encodings
// for the RAM burst controller.
package ram_pkg;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LW = 6;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Command, write-stream, read-stream and RAM-side signals of the burst controller.
// master = controller side, slave = the environment (command source, streams, RAM).
interface ram_burst_ctrl_if #(
  parameter int AW = ram_pkg::AW,
  parameter int DW = ram_pkg::DW,
  parameter int LW = ram_pkg::LW
);
  logic          start;
  logic          op;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          m_cen;
  logic          m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] m_din;

  modport master (
    input  start, op, base_addr, len, wr_data, wr_valid, m_din,
    output busy, done, wr_ready, rd_data, rd_valid, m_cen, m_wen, m_addr, m_dout
  );

  modport slave (
    output start, op, base_addr, len, wr_data, wr_valid, m_din,
    input  busy, done, wr_ready, rd_data, rd_valid, m_cen, m_wen, m_addr, m_dout
  );
endinterface

// File: rtl/ram_addr_cnt.sv
// Wrap-around RAM address counter paired with a remaining-beat down-counter.
// Loading with i_inc set consumes the first beat in the same edge.
module ram_addr_cnt #(
  parameter int AW = ram_pkg::AW,
  parameter int LW = ram_pkg::LW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_load,
  input  logic          i_inc,
  input  logic [AW-1:0] i_base,
  input  logic [LW-1:0] i_len,
  output logic [AW-1:0] o_addr,
  output logic          o_last,
  output logic          o_empty
);

  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_rem;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_base + AW'(i_inc);
      r_rem  <= i_len - LW'(i_inc);
    end else if (i_inc) begin
      r_addr <= r_addr + AW'(1);
      r_rem  <= r_rem - LW'(1);
    end
  end

  assign o_addr  = r_addr;
  assign o_last  = (r_rem == LW'(1));
  assign o_empty = (r_rem == '0);

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst master for the single-port RAM: turns a start command plus a
// valid/ready write stream into cen/wen cycles, and streams read words out.
//
// state   | meaning
// S_IDLE  | waiting for start; command accepted here only
// S_WRITE | accepting write beats, one RAM write per accepted beat
// S_READ  | presenting one read per cycle until all beats issued
// S_DRAIN | last RAM write / last rd_valid cycle in flight
// S_DONE  | one-cycle done pulse, then back to idle
module ram_burst_ctrl
  import ram_pkg::*;
#(
  parameter int AW = ram_pkg::AW,
  parameter int DW = ram_pkg::DW,
  parameter int LW = ram_pkg::LW
) (
  input logic              clk,
  input logic              reset_n,
  ram_burst_ctrl_if.master bus
);

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_m_cen;
  logic          r_m_wen;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_dout;
  logic          r_rd_valid;

  logic          w_cen;
  logic          w_wen;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_dout;
  logic          w_load;
  logic          w_inc;

  logic [LW-1:0] w_len;
  logic [AW-1:0] w_cnt_addr;
  logic          w_cnt_last;
  logic          w_cnt_empty;
  logic          w_wr_ready;
  logic          w_wr_accept;

  assign w_len       = (bus.len > LW'(2**AW)) ? LW'(2**AW) : bus.len;
  assign w_wr_ready  = (r_state == S_WRITE) && !w_cnt_empty;
  assign w_wr_accept = bus.wr_valid && w_wr_ready;

  ram_addr_cnt #(.AW(AW), .LW(LW)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_inc   (w_inc),
    .i_base  (bus.base_addr),
    .i_len   (w_len),
    .o_addr  (w_cnt_addr),
    .o_last  (w_cnt_last),
    .o_empty (w_cnt_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_len == '0)               w_state_nxt = S_DONE;
          else if (bus.op == OP_WRITE)   w_state_nxt = S_WRITE;
          else                           w_state_nxt = S_READ;
        end
      end
      S_READ:  if (w_cnt_empty) w_state_nxt = S_DRAIN;
      S_WRITE: if (w_wr_accept && w_cnt_last) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A read burst issues its first access straight from the start edge.
  always_comb begin
    w_cen  = 1'b0;
    w_wen  = 1'b0;
    w_addr = r_m_addr;
    w_dout = r_m_dout;
    w_load = 1'b0;
    w_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && (w_len != '0)) begin
          w_load = 1'b1;
          if (bus.op == OP_READ) begin
            w_inc  = 1'b1;
            w_cen  = 1'b1;
            w_addr = bus.base_addr;
          end
        end
      end
      S_READ: begin
        if (!w_cnt_empty) begin
          w_inc  = 1'b1;
          w_cen  = 1'b1;
          w_addr = w_cnt_addr;
        end
      end
      S_WRITE: begin
        if (w_wr_accept) begin
          w_inc  = 1'b1;
          w_cen  = 1'b1;
          w_wen  = 1'b1;
          w_addr = w_cnt_addr;
          w_dout = bus.wr_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_m_cen    <= 1'b0;
      r_m_wen    <= 1'b0;
      r_m_addr   <= '0;
      r_m_dout   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_m_cen    <= w_cen;
      r_m_wen    <= w_wen;
      r_m_addr   <= w_addr;
      r_m_dout   <= w_dout;
      r_rd_valid <= r_m_cen && !r_m_wen;
    end
  end

  assign bus.m_cen    = r_m_cen;
  assign bus.m_wen    = r_m_wen;
  assign bus.m_addr   = r_m_addr;
  assign bus.m_dout   = r_m_dout;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = bus.m_din;
  assign bus.wr_ready = w_wr_ready;
  assign bus.busy     = (r_state == S_READ) || (r_state == S_WRITE) || (r_state == S_DRAIN);
  assign bus.done     = (r_state == S_DONE);

endmodule
